// File: rtl/rot_pkg.sv
// Shared constants, types and helpers for the rotate/arbiter slice.
//   ROT_W / AMT_W          : operand width and rotate-amount width
//   DIR_RIGHT / DIR_LEFT   : encoding of the per-request direction bit
//   out_state_e            : occupancy state of the one-deep output stage
//   left_to_right_amt(amt) : right-rotate amount equivalent to a left rotate by amt
package rot_pkg;

    localparam int unsigned ROT_W = 16;
    localparam int unsigned AMT_W = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Rotating left by n equals rotating right by (ROT_W - n) mod ROT_W.
    function automatic logic [AMT_W-1:0] left_to_right_amt(input logic [AMT_W-1:0] amt);
        return AMT_W'(0 - amt);
    endfunction

endpackage

// File: rtl/ror_shifter16.sv
// Combinational 16-bit rotate-right.
//   din  : operand
//   s    : rotate-right amount, 0..15
//   dout : din rotated right by s
module ror_shifter16
    import rot_pkg::*;
(
    input  logic [ROT_W-1:0] din,
    input  logic [AMT_W-1:0] s,
    output logic [ROT_W-1:0] dout
);

    logic [2*ROT_W-1:0] dbl;

    // Shifting the doubled operand right leaves the rotated word in the low half.
    always_comb begin
        dbl  = {din, din} >> s;
        dout = dbl[ROT_W-1:0];
    end

endmodule

// File: rtl/ror_arb16.sv
// Two-requester arbiter sharing one rotate-right shifter, with a one-deep
// valid/ready output register tagged by source and saturating grant counters.
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/ready/data/amt/dir  : requester N handshake and operation (N = 0, 1)
//   out_valid/out_ready            : output stage handshake
//   out_data, out_src              : rotated result and index of its requester
//   grant_cnt0, grant_cnt1         : saturating counts of accepted operations
module ror_arb16
    import rot_pkg::*;
#(
    parameter bit          RR_EN = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ROT_W-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ROT_W-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROT_W-1:0] out_data,
    output logic             out_src,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    out_state_e       state_q, state_d;
    logic             last_grant;
    logic             can_accept;
    logic             grant_any;
    logic             grant;
    logic             accept;
    logic [ROT_W-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic             sel_dir;
    logic [AMT_W-1:0] eff_amt;
    logic [ROT_W-1:0] rot_data;

    // Output-stage FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-stage FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept)                   state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept)     state_d = ST_EMPTY;
            default:                                state_d = ST_EMPTY;
        endcase
    end

    // Output-stage FSM: outputs
    always_comb begin
        out_valid  = (state_q == ST_FULL);
        can_accept = !rst && (!out_valid || out_ready);
    end

    // Arbiter: a contest only arises when both requesters are valid
    always_comb begin
        grant_any = req0_valid || req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = can_accept && grant_any;
        req0_ready = accept && req0_valid && (grant == 1'b0);
        req1_ready = accept && req1_valid && (grant == 1'b1);
    end

    // Operand mux feeding the shared shifter
    always_comb begin
        sel_data = grant ? req1_data : req0_data;
        sel_amt  = grant ? req1_amt  : req0_amt;
        sel_dir  = grant ? req1_dir  : req0_dir;
        eff_amt  = (sel_dir == DIR_LEFT) ? left_to_right_amt(sel_amt) : sel_amt;
    end

    ror_shifter16 u_shifter (
        .din  (sel_data),
        .s    (eff_amt),
        .dout (rot_data)
    );

    // Result register, round-robin pointer and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            out_data   <= rot_data;
            out_src    <= grant;
            last_grant <= grant;
            if (grant == 1'b0) begin
                if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end else begin
                if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ror_arb16.sv
module tb_ror_arb16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data,  req1_data;
    logic [3:0]  req0_amt,   req1_amt;
    logic        req0_dir,   req1_dir;
    logic        out_ready;

    // round-robin instance
    logic        rr_r0, rr_r1, rr_ov, rr_src;
    logic [15:0] rr_od, rr_c0, rr_c1;
    // fixed-priority instance
    logic        fp_r0, fp_r1, fp_ov, fp_src;
    logic [15:0] fp_od, fp_c0, fp_c1;
    // narrow-counter instance
    logic        sa_r0, sa_r1, sa_ov, sa_src;
    logic [15:0] sa_od;
    logic [1:0]  sa_c0, sa_c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ror_arb16 #(.RR_EN(1'b1), .CNT_W(16)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_data(req0_data), .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_data(req1_data), .req1_amt(req1_amt), .req1_dir(req1_dir),
        .out_valid(rr_ov), .out_ready(out_ready), .out_data(rr_od), .out_src(rr_src),
        .grant_cnt0(rr_c0), .grant_cnt1(rr_c1)
    );

    ror_arb16 #(.RR_EN(1'b0), .CNT_W(16)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_data(req0_data), .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_data(req1_data), .req1_amt(req1_amt), .req1_dir(req1_dir),
        .out_valid(fp_ov), .out_ready(out_ready), .out_data(fp_od), .out_src(fp_src),
        .grant_cnt0(fp_c0), .grant_cnt1(fp_c1)
    );

    ror_arb16 #(.RR_EN(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(sa_r0), .req0_data(req0_data), .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(sa_r1), .req1_data(req1_data), .req1_amt(req1_amt), .req1_dir(req1_dir),
        .out_valid(sa_ov), .out_ready(out_ready), .out_data(sa_od), .out_src(sa_src),
        .grant_cnt0(sa_c0), .grant_cnt1(sa_c1)
    );

    // Reference rotate straight from the definition: bit i of a right rotate
    // by n is bit (i+n) mod 16; a left rotate by n takes bit (i-n) mod 16.
    function automatic logic [15:0] ref_rot(input logic [15:0] d, input int amt, input logic left);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            if (left) r[i] = d[(i - amt + 16) % 16];
            else      r[i] = d[(i + amt) % 16];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        req0_amt = '0;  req1_amt = '0;
        req0_dir = 1'b0; req1_dir = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({rr_r0, rr_r1, fp_r0, fp_r1} !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b, want 0000", {rr_r0, rr_r1, fp_r0, fp_r1});
        end
        step();
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if ({rr_ov, rr_src, fp_ov, sa_ov} !== 4'b0000 || rr_od !== 16'h0000) begin
            errors++; $display("FAIL reset_out: got ov=%b src=%b data=%h, want 0 0 0000", rr_ov, rr_src, rr_od);
        end
        checks++;
        if (rr_c0 !== 16'd0 || rr_c1 !== 16'd0 || sa_c0 !== 2'd0 || sa_c1 !== 2'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d %0d %0d, want 0", rr_c0, rr_c1, sa_c0, sa_c1);
        end
    endtask

    task automatic test_req0_only();
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h1234; req0_amt = 4'd4; req0_dir = 1'b0;
        #1;
        checks++;
        if (rr_r0 !== 1'b1 || rr_r1 !== 1'b0) begin
            errors++; $display("FAIL req0_ready: got %b%b, want 10", rr_r0, rr_r1);
        end
        step();
        idle_inputs();
        checks++;
        if (rr_ov !== 1'b1 || rr_od !== 16'h4123 || rr_src !== 1'b0 || rr_c0 !== 16'd1) begin
            errors++; $display("FAIL req0_result: got ov=%b data=%h src=%b cnt0=%0d, want 1 4123 0 1",
                               rr_ov, rr_od, rr_src, rr_c0);
        end
        step();
        checks++;
        if (rr_ov !== 1'b0 || rr_od !== 16'h4123) begin
            errors++; $display("FAIL drain_empty: got ov=%b data=%h, want 0 4123", rr_ov, rr_od);
        end
    endtask

    task automatic test_req1_only();
        do_reset();
        req1_valid = 1'b1; req1_data = 16'h8001; req1_amt = 4'd1; req1_dir = 1'b1;
        step();
        req1_amt = 4'd0;
        checks++;
        if (rr_od !== 16'h0003 || rr_src !== 1'b1 || rr_c1 !== 16'd1) begin
            errors++; $display("FAIL req1_left1: got data=%h src=%b cnt1=%0d, want 0003 1 1", rr_od, rr_src, rr_c1);
        end
        step();
        idle_inputs();
        checks++;
        if (rr_od !== 16'h8001 || rr_ov !== 1'b1) begin
            errors++; $display("FAIL req1_left0: got data=%h ov=%b, want 8001 1", rr_od, rr_ov);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h00F0; req0_amt = 4'd4; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 16'h0F00; req1_amt = 4'd4; req1_dir = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic exp_g;
            exp_g = (c % 2 == 1);
            #1;
            checks++;
            if (rr_r0 !== !exp_g || rr_r1 !== exp_g) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b%b, want %b%b", c, rr_r0, rr_r1, !exp_g, exp_g);
            end
            checks++;
            if (fp_r0 !== 1'b1 || fp_r1 !== 1'b0) begin
                errors++; $display("FAIL fp_ready[%0d]: got %b%b, want 10", c, fp_r0, fp_r1);
            end
            step();
            checks++;
            if (rr_src !== exp_g || rr_od !== (exp_g ? 16'hF000 : 16'h000F) || rr_ov !== 1'b1) begin
                errors++; $display("FAIL rr_out[%0d]: got src=%b data=%h, want %b %h", c, rr_src, rr_od,
                                   exp_g, exp_g ? 16'hF000 : 16'h000F);
            end
        end
        idle_inputs();
        checks++;
        if (rr_c0 !== 16'd2 || rr_c1 !== 16'd2) begin
            errors++; $display("FAIL rr_cnt: got %0d %0d, want 2 2", rr_c0, rr_c1);
        end
        checks++;
        if (fp_c0 !== 16'd4 || fp_c1 !== 16'd0 || fp_src !== 1'b0) begin
            errors++; $display("FAIL fp_cnt: got %0d %0d src=%b, want 4 0 0", fp_c0, fp_c1, fp_src);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        do_reset();
        req0_valid = 1'b1; req0_data = 16'hABCD; req0_amt = 4'd8; req0_dir = 1'b0;
        out_ready = 1'b0;
        step();
        held = 16'hCDAB;
        req0_data = 16'h1111; req0_amt = 4'd1;
        req1_valid = 1'b1; req1_data = 16'h0001; req1_amt = 4'd3; req1_dir = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rr_r0 !== 1'b0 || rr_r1 !== 1'b0 || rr_ov !== 1'b1 || rr_od !== held) begin
                errors++; $display("FAIL bp_hold[%0d]: got rdy=%b%b ov=%b data=%h, want 00 1 %h",
                                   c, rr_r0, rr_r1, rr_ov, rr_od, held);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rr_r1 !== 1'b1 || rr_r0 !== 1'b0) begin
            errors++; $display("FAIL bp_release_ready: got %b%b, want 01", rr_r0, rr_r1);
        end
        step();
        idle_inputs();
        checks++;
        if (rr_ov !== 1'b1 || rr_od !== 16'h2000 || rr_src !== 1'b1) begin
            errors++; $display("FAIL bp_refill: got ov=%b data=%h src=%b, want 1 2000 1", rr_ov, rr_od, rr_src);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h5555; req0_amt = 4'd1;
        req1_valid = 1'b1; req1_data = 16'h3333; req1_amt = 4'd2;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (rr_r0 !== 1'b0 || rr_r1 !== 1'b0 || rr_ov !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready: got rdy=%b%b ov=%b, want 00 1", rr_r0, rr_r1, rr_ov);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (rr_ov !== 1'b0 || rr_c0 !== 16'd0 || rr_c1 !== 16'd0) begin
            errors++; $display("FAIL rst_mid_state: got ov=%b cnt=%0d %0d, want 0 0 0", rr_ov, rr_c0, rr_c1);
        end
        checks++;
        if (rr_r0 !== 1'b1 || rr_r1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_first: got %b%b, want 10", rr_r0, rr_r1);
        end
        step();
        idle_inputs();
        checks++;
        if (rr_src !== 1'b0 || rr_od !== 16'hAAAA) begin
            errors++; $display("FAIL rst_mid_out: got src=%b data=%h, want 0 aaaa", rr_src, rr_od);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h00FF;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (int'(sa_c0) !== ((c > 3) ? 3 : c) || int'(rr_c0) !== c) begin
                errors++; $display("FAIL sat_cnt[%0d]: got narrow=%0d wide=%0d, want %0d %0d",
                                   c, sa_c0, rr_c0, (c > 3) ? 3 : c, c);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random_sweep();
        do_reset();
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] v;
                logic        who;
                logic [15:0] exp;
                v   = 16'($urandom);
                who = 1'($urandom_range(0, 1));
                exp = ref_rot(v, a, d[0]);
                idle_inputs();
                if (who) begin
                    req1_valid = 1'b1; req1_data = v; req1_amt = 4'(a); req1_dir = d[0];
                end else begin
                    req0_valid = 1'b1; req0_data = v; req0_amt = 4'(a); req0_dir = d[0];
                end
                step();
                checks++;
                if (rr_od !== exp || rr_src !== who || fp_od !== exp) begin
                    errors++; $display("FAIL sweep amt=%0d dir=%0d data=%h: got rr=%h fp=%h src=%b, want %h src=%b",
                                       a, d, v, rr_od, fp_od, rr_src, exp, who);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_req0_only();
        test_req1_only();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
